// File: rtl/ex_div_seq.sv
// Iterative RV32M divide/remainder sequencer: restoring radix-2, one quotient bit per cycle.
// Latency: DATA_WIDTH+1 cycles from accept to res_valid_o (fast path: 1 cycle).
// Backpressure: result held in DONE until res_ready_i; busy_o stalls upstream while not IDLE.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/req_ready_o request handshake; op_i (00 DIV, 01 DIVU, 10 REM, 11 REMU), a_i dividend, b_i divisor
//   flush_i                abort whatever is in flight, back to IDLE next edge
//   res_valid_o/res_ready_i result handshake; result_o quotient or remainder
//   busy_o                 registered stall towards the ID/EX pipeline
//
// DATA_WIDTH must be a power of 2 and at least 8.
module ex_div_seq #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  flush_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  busy_o
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W) + 1;

    localparam logic [W-1:0]  ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] CNT_LOAD = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    rem_q;      // partial remainder
    logic [W-1:0]    quo_q;      // dividend bits shift out of the top, quotient bits in at the bottom
    logic [W-1:0]    dvs_q;      // divisor magnitude
    logic            is_rem_q;   // REM/REMU: deliver remainder instead of quotient
    logic            neg_quo_q;  // signed op with differing operand signs
    logic            neg_rem_q;  // signed op with negative dividend
    logic [W-1:0]    result_q;
    logic            req_ready_q;
    logic            busy_q;
    logic            res_valid_q;

    // ------------------------------------------------------------------
    // Request decode (only meaningful in the accept cycle)
    // ------------------------------------------------------------------
    logic            op_signed;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_abs;
    logic [W-1:0]    b_abs;
    logic            div_zero;
    logic            sgn_ovf;
    logic            fast_path;
    logic [W-1:0]    fast_res;

    always_comb begin
        op_signed = ~op_i[0];
        op_rem    = op_i[1];
        a_neg     = op_signed & a_i[W-1];
        b_neg     = op_signed & b_i[W-1];
        // Two's complement of the most negative value is itself, which read
        // as unsigned is exactly its magnitude, so no special case is needed.
        a_abs     = a_neg ? (~a_i + ONE) : a_i;
        b_abs     = b_neg ? (~b_i + ONE) : b_i;
        div_zero  = (b_i == '0);
        sgn_ovf   = op_signed && (a_i == MIN_NEG) && (b_i == '1);
        fast_path = div_zero | sgn_ovf;

        fast_res = '0;
        if (div_zero) begin
            fast_res = op_rem ? a_i : '1;
        end else if (sgn_ovf) begin
            fast_res = op_rem ? '0 : MIN_NEG;
        end
    end

    // ------------------------------------------------------------------
    // One restoring iteration and the sign-corrected final result
    // ------------------------------------------------------------------
    logic [W:0]      shifted;
    logic [W+1:0]    trial;
    logic            trial_ok;
    logic [W-1:0]    rem_d;
    logic [W-1:0]    quo_d;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;
    logic [W-1:0]    result_d;
    logic            unused_trial_bit;

    always_comb begin
        // Remainder gains one dividend bit; an extra top bit keeps the
        // shifted value exact, a second one gives the borrow of the trial.
        shifted  = {rem_q, quo_q[W-1]};
        trial    = {1'b0, shifted} - {2'b00, dvs_q};
        trial_ok = ~trial[W+1];
        // A successful trial always leaves a value below the divisor, so
        // bit W of the difference is zero; a failed one had shifted[W] = 0.
        rem_d    = trial_ok ? trial[W-1:0] : shifted[W-1:0];
        quo_d    = {quo_q[W-2:0], trial_ok};

        quo_fix  = neg_quo_q ? (~quo_d + ONE) : quo_d;
        rem_fix  = neg_rem_q ? (~rem_d + ONE) : rem_d;
        result_d = is_rem_q ? rem_fix : quo_fix;
    end

    assign unused_trial_bit = trial[W];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            is_rem_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_q    <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else if (flush_i) begin
            // Abort beats accept, iteration and the result handshake alike.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        is_rem_q    <= op_rem;
                        neg_quo_q   <= a_neg ^ b_neg;
                        neg_rem_q   <= a_neg;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (fast_path) begin
                            result_q    <= fast_res;
                            res_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= a_abs;
                            dvs_q   <= b_abs;
                            cnt_q   <= CNT_LOAD;
                            state_q <= S_BUSY;
                        end
                    end
                end

                S_BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    // Last quotient bit is produced this cycle; register the
                    // corrected result together with the move to DONE.
                    if (cnt_q == CNT_ONE) begin
                        result_q    <= result_d;
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Going back through IDLE keeps a new accept out of the
                    // handshake cycle.
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq: directed corner cases plus random operations against an arithmetic model.
// Latency: checks accept-to-valid cycle counts (W+1 normal, 1 fast path).
// Backpressure: exercises held DONE with res_ready_i low, flush and asynchronous reset.
module tb_ex_div_seq;

    localparam int unsigned W = 32;

    logic          clk_i;
    logic          rst_ni;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [1:0]    op_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          flush_i;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [W-1:0]  result_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;

    ex_div_seq #(.DATA_WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .flush_i     (flush_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV32M semantics straight from the arithmetic definitions.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Issue one request from IDLE, scramble the operand inputs afterwards,
    // measure latency and check the result and the return to IDLE.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res);
        int lat;
        @(negedge clk_i);
        check_eq({tag, "_rdy"}, {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        op_i = op;
        a_i  = a;
        b_i  = b;
        res_ready_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        op_i = 2'($urandom);
        a_i  = $urandom;
        b_i  = $urandom;
        check_eq({tag, "_busy_c1"}, {30'd0, busy_o, req_ready_o}, 32'd2);
        lat = 1;
        while (!res_valid_o && lat < 200) begin
            @(negedge clk_i);
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(ref_latency(op, a, b)));
        check_eq({tag, "_res"}, result_o, exp_res);
        @(negedge clk_i);
        check_eq({tag, "_idle"}, {30'd0, req_ready_o, res_valid_o}, 32'd2);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       tag;
    } vec_t;

    vec_t dir_tbl[$];

    initial begin
        int idle_cnt;
        int vld_seen;
        int wcnt;
        logic [31:0] held;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_ni = 1'b0;
        req_valid_i = 1'b0;
        op_i = 2'b00;
        a_i = '0;
        b_i = '0;
        flush_i = 1'b0;
        res_ready_i = 1'b1;

        #12;
        check_eq("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check_eq("rst_valid", {31'd0, res_valid_o}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy_o}, 32'd0);
        check_eq("rst_result", result_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        dir_tbl.push_back('{2'b01, 32'd100, 32'd7, 32'd14, "divu_100_7"});
        dir_tbl.push_back('{2'b11, 32'd100, 32'd7, 32'd2, "remu_100_7"});
        dir_tbl.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2"});
        dir_tbl.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2"});
        dir_tbl.push_back('{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem_7_m2"});
        dir_tbl.push_back('{2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_5_0"});
        dir_tbl.push_back('{2'b11, 32'd5, 32'd0, 32'd5, "remu_5_0"});
        dir_tbl.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
        dir_tbl.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf"});
        dir_tbl.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "divu_max_1"});
        dir_tbl.push_back('{2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, "div_min_2"});
        foreach (dir_tbl[i]) do_op(dir_tbl[i].tag, dir_tbl[i].op, dir_tbl[i].a, dir_tbl[i].b, dir_tbl[i].exp);

        // Back-pressure: DONE held with res_ready_i low, new requests ignored.
        @(negedge clk_i);
        res_ready_i = 1'b0;
        req_valid_i = 1'b1;
        op_i = 2'b01;
        a_i = 32'd1000;
        b_i = 32'd10;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        wcnt = 0;
        while (!res_valid_o && wcnt < 200) begin
            @(negedge clk_i);
            wcnt++;
        end
        check_eq("bp_res", result_o, 32'd100);
        held = result_o;
        req_valid_i = 1'b1;
        op_i = 2'b11;
        a_i = 32'd77;
        b_i = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check_eq("bp_hold", {result_o[31:3], res_valid_o, req_ready_o, busy_o}, {held[31:3], 3'b101});
            check_eq("bp_hold_res", result_o, held);
        end
        req_valid_i = 1'b0;
        res_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("bp_release", {30'd0, req_ready_o, res_valid_o}, 32'd2);
        @(negedge clk_i);
        check_eq("bp_no_stale_req", {30'd0, req_ready_o, busy_o}, 32'd2);

        // Flush at BUSY cycle 10.
        req_valid_i = 1'b1;
        op_i = 2'b01;
        a_i = 32'h0000_FFFF;
        b_i = 32'd3;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk_i);
        check_eq("fl_busy10", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check_eq("fl_idle", {29'd0, req_ready_o, busy_o, res_valid_o}, 32'd4);
        vld_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (res_valid_o) vld_seen++;
        end
        check_eq("fl_no_valid", 32'(vld_seen), 32'd0);
        do_op("fl_after_divu", 2'b01, 32'd9, 32'd3, 32'd3);

        // Flush wins over an accept in IDLE.
        @(negedge clk_i);
        req_valid_i = 1'b1;
        flush_i = 1'b1;
        op_i = 2'b01;
        a_i = 32'd8;
        b_i = 32'd0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        flush_i = 1'b0;
        check_eq("fl_blocks_accept", {29'd0, req_ready_o, busy_o, res_valid_o}, 32'd4);

        // Flush in DONE drops the pending result.
        res_ready_i = 1'b0;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check_eq("fl_done_pre", {31'd0, res_valid_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        res_ready_i = 1'b1;
        check_eq("fl_done_post", {29'd0, req_ready_o, busy_o, res_valid_o}, 32'd4);

        // Asynchronous reset in the middle of BUSY.
        req_valid_i = 1'b1;
        op_i = 2'b00;
        a_i = 32'd12345;
        b_i = 32'd11;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_outs", {28'd0, req_ready_o, res_valid_o, busy_o, 1'b0}, 32'd8);
        check_eq("arst_result", result_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_op("b2b_1", 2'b00, 32'hFFFF_FF00, 32'd16, 32'hFFFF_FFF0);
        do_op("b2b_2", 2'b11, 32'd1_000_003, 32'd1000, 32'd3);

        // Random operations against the arithmetic model.
        for (int n = 0; n < 60; n++) begin
            rop = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            do_op("rand", rop, ra, rb, ref_result(rop, ra, rb));
        end

        idle_cnt = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (req_ready_o) idle_cnt++;
        end
        check_eq("final_idle", 32'(idle_cnt), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
